// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

    // Default generator counter width; the capture block measures with one extra bit.
    localparam int PWM_BIT_WIDTH = 16;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// previous-level flop used for single-cycle rise/fall detection.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus the delayed copy. Everything resets to 0, so
    // releasing reset can never look like a rising edge by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles.
// A result is published on every rising edge that closes a full period, or
// as a timeout when no rising edge arrives within cnt_max cycles.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int bit_width = PWM_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [bit_width:0]   high_time,
    output logic [bit_width:0]   period,
    output logic                 meas_valid,
    output logic                 timeout
);

    localparam int CW = bit_width + 1;
    localparam logic [CW-1:0] cnt_max = '1;

    logic            w_sync;
    logic            w_rise;
    logic            w_fall;
    logic            w_timeout_hit;

    pwm_state_t      r_state;
    logic [CW-1:0]   r_period_cnt;
    logic [CW-1:0]   r_high_cnt;
    logic [CW-1:0]   r_idle_cnt;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pwm_in),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // A rise in the same cycle wins over the timeout.
    assign w_timeout_hit = (r_idle_cnt == cnt_max) && !w_rise;

    // Cycles since the last rise or timeout. Restarting at 1 counts the restart
    // cycle itself, so stuck-input timeouts repeat exactly every cnt_max cycles
    // and the counter can never pass cnt_max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_rise || w_timeout_hit) begin
            r_idle_cnt <= CW'(1);
        end else begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
        end
    end

    // Measurement FSM with registered results. The rise cycle counts as the
    // first high cycle and the fall cycle as the first low cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            high_time    <= '0;
            period       <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (w_rise) begin
                // Only a rise seen from LOW closes a complete period; from IDLE
                // any partial period is discarded.
                if (r_state == LOW) begin
                    period     <= r_period_cnt;
                    high_time  <= r_high_cnt;
                    timeout    <= 1'b0;
                    meas_valid <= 1'b1;
                end
                r_period_cnt <= CW'(1);
                r_high_cnt   <= CW'(1);
                r_state      <= HIGH;
            end else if (w_timeout_hit) begin
                period       <= '0;
                high_time    <= w_sync ? cnt_max : '0;
                timeout      <= 1'b1;
                meas_valid   <= 1'b1;
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
                r_state      <= IDLE;
            end else begin
                case (r_state)
                    HIGH: begin
                        r_period_cnt <= r_period_cnt + CW'(1);
                        if (w_fall) begin
                            r_state <= LOW;
                        end else begin
                            r_high_cnt <= r_high_cnt + CW'(1);
                        end
                    end
                    LOW: begin
                        r_period_cnt <= r_period_cnt + CW'(1);
                    end
                    default: begin
                        r_period_cnt <= r_period_cnt;
                    end
                endcase
            end
        end
    end

endmodule
